// File: rtl/fp_mul_pkg.sv
// Shared types and FP32 field constants for the shared multiplier arbiter.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESP    = 2'd2
    } fsm_state_t;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int SIGN_BIT = 31;

endpackage

// File: rtl/BOOTH_16_BIT.sv
// Combinational FP32 multiplier: no rounding, no denormal/NaN handling.
module BOOTH_16_BIT
    import fp_mul_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result,
    output logic        o_overflow
);

    logic [23:0] w_ma;
    logic [23:0] w_mb;
    logic [47:0] w_prod;
    logic        w_carry;
    logic [22:0] w_mant;
    logic [8:0]  w_exp;
    logic        w_unused;

    // Hidden bit is always set; exponent-zero inputs are not special-cased.
    assign w_ma    = {1'b1, i_a[EXP_LSB-1:0]};
    assign w_mb    = {1'b1, i_b[EXP_LSB-1:0]};
    assign w_prod  = w_ma * w_mb;
    assign w_carry = w_prod[47];
    assign w_mant  = w_carry ? w_prod[46:24] : w_prod[45:23];

    assign w_exp = {1'b0, i_a[EXP_MSB:EXP_LSB]}
                 + {1'b0, i_b[EXP_MSB:EXP_LSB]}
                 + {8'd0, w_carry}
                 - 9'(EXP_BIAS);

    assign o_result   = {i_a[SIGN_BIT] ^ i_b[SIGN_BIT], w_exp[7:0], w_mant};
    assign o_overflow = w_exp[8];
    assign w_unused   = ^w_prod[22:0];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting at i_ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_valid,
    output logic [ID_W-1:0] o_idx,
    output logic [N-1:0]    o_onehot
);

    localparam int SW = ID_W + 1;

    logic [SW-1:0]   w_sum;
    logic [ID_W-1:0] w_j;

    // Scan farthest-first so the candidate nearest the pointer wins.
    always_comb begin
        o_valid  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_sum    = '0;
        w_j      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + SW'(k);
            if (w_sum >= SW'(N)) begin
                w_sum = w_sum - SW'(N);
            end
            w_j = w_sum[ID_W-1:0];
            if (i_req[w_j]) begin
                o_valid       = 1'b1;
                o_idx         = w_j;
                o_onehot      = '0;
                o_onehot[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one FP32 multiplier among NUM_REQ requesters.
// Optional FPMUL_ZERO_FLUSH_EN: zero-exponent operands give a signed zero.
module fp_mul_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int MUL_WAIT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_result,
    output logic                  rsp_overflow,
    output logic                  busy
);

    import fp_mul_pkg::*;

    localparam int CNT_W = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

    fsm_state_t       r_state;
    fsm_state_t       w_next;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;

    logic               w_gnt_valid;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic [31:0]        w_mul_res;
    logic               w_mul_ovf;
    logic [31:0]        w_res;
    logic               w_ovf;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_valid  (w_gnt_valid),
        .o_idx    (w_gnt_idx),
        .o_onehot (w_gnt_onehot)
    );

    BOOTH_16_BIT u_mul (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .o_result   (w_mul_res),
        .o_overflow (w_mul_ovf)
    );

`ifdef FPMUL_ZERO_FLUSH_EN
    logic w_zero;
    assign w_zero = (r_op_a[EXP_MSB:EXP_LSB] == '0)
                 || (r_op_b[EXP_MSB:EXP_LSB] == '0);
    assign w_res  = w_zero
                  ? {r_op_a[SIGN_BIT] ^ r_op_b[SIGN_BIT], 31'd0}
                  : w_mul_res;
    assign w_ovf  = w_mul_ovf & ~w_zero;
`else
    assign w_res = w_mul_res;
    assign w_ovf = w_mul_ovf;
`endif

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        unique case (r_state)
            IDLE: begin
                if (!rst) begin
                    req_ready = w_gnt_onehot;
                end
                if (w_gnt_valid) begin
                    w_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (r_cnt == '0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_op_a <= req_a[{w_gnt_idx, 5'd0} +: 32];
                        r_op_b <= req_b[{w_gnt_idx, 5'd0} +: 32];
                        r_id   <= w_gnt_idx;
                        r_cnt  <= CNT_W'(MUL_WAIT - 1);
                        r_ptr  <= (w_gnt_idx == ID_W'(NUM_REQ - 1))
                                ? '0 : w_gnt_idx + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (r_cnt == '0) begin
                        rsp_result   <= w_res;
                        rsp_overflow <= w_ovf;
                        rsp_id       <= r_id;
                        rsp_valid    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
